md_unit_ctrl: RTL

- Sequences the multi-cycle multiply/divide resource in the E stage of the 5-stage pipeline and owns the HI/LO architectural registers.
- Accepts one operation per start, models multiplier/divider latency with a countdown, and commits results to HI/LO at completion.
- Exports busy information to the hazard/stall logic, so D-stage mult/div/mfhi/mflo/mthi/mtlo instructions stall while the unit is occupied.
- HI/LO are read combinationally by the E-stage result mux for mfhi/mflo.

---
 rtl/md_unit_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/md_unit_ctrl.sv
// HI/LO owner and multi-cycle mult/div sequencer for the E stage; results commit N cycles after start.
// Latency MULT_CYCLES/DIV_CYCLES; starts arriving while busy are dropped, md_hazard tells the stall unit.
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        md_hazard,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       pend_hi, pend_lo;

    logic              start_long, signed_op, div_op, neg_q, neg_r;
    logic [31:0]       mag_a, mag_b, quo, rem, res_hi, res_lo;
    logic [63:0]       prod;

    assign start_long = start & ~md_op[2];
    assign md_hazard  = start_long | busy;

    // Division works on magnitudes so the -2^31 / -1 case falls out naturally.
    always_comb begin
        signed_op = ~md_op[0];
        div_op    = md_op[1];
        mag_a     = (signed_op && a[31]) ? -a : a;
        mag_b     = (signed_op && b[31]) ? -b : b;
        neg_q     = signed_op & (a[31] ^ b[31]);
        neg_r     = signed_op & a[31];
        quo       = '0;
        rem       = '0;
        if (mag_b != '0) begin
            quo = mag_a / mag_b;
            rem = mag_a % mag_b;
        end
        prod = {{32{signed_op & a[31]}}, a} * {{32{signed_op & b[31]}}, b};
        if (!div_op) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else if (b == '0) begin
            res_hi = hi;
            res_lo = lo;
        end else begin
            res_hi = neg_r ? -rem : rem;
            res_lo = neg_q ? -quo : quo;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_long) begin
                        pend_hi <= res_hi;
                        pend_lo <= res_lo;
                        cnt     <= div_op ? DIV_N : MULT_N;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else if (start && md_op == 3'd4) begin
                        hi <= a;
                    end else if (start && md_op == 3'd5) begin
                        lo <= a;
                    end
                end
                RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        hi    <= pend_hi;
                        lo    <= pend_lo;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
